// File: rtl/uart_tx.sv
// UART transmitter: byte FIFO feeding an 8N1 serialiser (8E1/8E2 when the
// UART_TX_PARITY_EN macro is defined), idle-high line, STOP_BITS stop bits.
module uart_tx #(
   parameter int CLKS_PER_BIT = 422,
   parameter int FIFO_DEPTH   = 4,
   parameter int STOP_BITS    = 1
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic [7:0] i_data,
   input  logic       i_data_valid,
   output logic       o_ready,
   output logic       o_txd,
   output logic       o_busy
);

   localparam int CNT_W  = $clog2(CLKS_PER_BIT);
   localparam int PTR_W  = $clog2(FIFO_DEPTH);
   localparam int FCNT_W = PTR_W + 1;

   localparam logic [CNT_W-1:0]  BAUD_MAX  = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [FCNT_W-1:0] FIFO_FULL = FCNT_W'(FIFO_DEPTH);
   localparam logic [2:0]        STOP_LAST = 3'(STOP_BITS - 1);

   if (CLKS_PER_BIT < 2) begin : g_bad_clks
      $error("uart_tx: CLKS_PER_BIT must be at least 2");
   end
   if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
      $error("uart_tx: FIFO_DEPTH must be a power of two, at least 2");
   end
   if ((STOP_BITS != 1) && (STOP_BITS != 2)) begin : g_bad_stop
      $error("uart_tx: STOP_BITS must be 1 or 2");
   end

`ifdef UART_TX_PARITY_EN
   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
   typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

   state_t              state_q, state_d;
   logic [CNT_W-1:0]    baud_q, baud_d;
   logic [2:0]          bit_idx_q, bit_idx_d;
   logic                txd_q, txd_d;
   logic                ready_q, ready_d;
   logic                busy_q, busy_d;
   logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
   logic [FCNT_W-1:0]   count_q, count_d;
   logic [7:0]          shift_q, shift_d;
`ifdef UART_TX_PARITY_EN
   logic                parity_q, parity_d;
`endif
   logic [7:0]          mem_q [FIFO_DEPTH];

   logic                push;
   logic                pop;
   logic                fifo_empty;
   logic                bit_end;
   logic [7:0]          head;

   assign push       = i_data_valid & ready_q;
   assign fifo_empty = (count_q == '0);
   assign bit_end    = (baud_q == BAUD_MAX);
   assign head       = mem_q[rd_ptr_q];

   // Frame sequencing; pop is raised only when a new frame is loaded.
   always_comb begin
      state_d   = state_q;
      bit_idx_d = bit_idx_q;
      txd_d     = txd_q;
      shift_d   = shift_q;
`ifdef UART_TX_PARITY_EN
      parity_d  = parity_q;
`endif
      pop       = 1'b0;
      baud_d    = bit_end ? '0 : baud_q + 1'b1;

      case (state_q)
         S_IDLE: begin
            txd_d  = 1'b1;
            baud_d = '0;
            if (!fifo_empty) begin
               pop = 1'b1;
            end
         end
         S_START: begin
            if (bit_end) begin
               state_d   = S_DATA;
               bit_idx_d = 3'd0;
               txd_d     = shift_q[0];
            end
         end
         S_DATA: begin
            if (bit_end) begin
               if (bit_idx_q == 3'd7) begin
                  bit_idx_d = 3'd0;
`ifdef UART_TX_PARITY_EN
                  state_d   = S_PARITY;
                  txd_d     = parity_q;
`else
                  state_d   = S_STOP;
                  txd_d     = 1'b1;
`endif
               end else begin
                  bit_idx_d = bit_idx_q + 3'd1;
                  shift_d   = {1'b0, shift_q[7:1]};
                  txd_d     = shift_q[1];
               end
            end
         end
`ifdef UART_TX_PARITY_EN
         S_PARITY: begin
            if (bit_end) begin
               state_d   = S_STOP;
               bit_idx_d = 3'd0;
               txd_d     = 1'b1;
            end
         end
`endif
         S_STOP: begin
            txd_d = 1'b1;
            if (bit_end) begin
               if (bit_idx_q == STOP_LAST) begin
                  bit_idx_d = 3'd0;
                  if (fifo_empty) begin
                     state_d = S_IDLE;
                  end else begin
                     pop = 1'b1;
                  end
               end else begin
                  bit_idx_d = bit_idx_q + 3'd1;
               end
            end
         end
         default: begin
            state_d   = S_IDLE;
            bit_idx_d = 3'd0;
            txd_d     = 1'b1;
            baud_d    = '0;
         end
      endcase

      // Loading a byte starts the next start bit on this same edge.
      if (pop) begin
         state_d   = S_START;
         shift_d   = head;
         txd_d     = 1'b0;
         baud_d    = '0;
         bit_idx_d = 3'd0;
`ifdef UART_TX_PARITY_EN
         parity_d  = ^head;
`endif
      end
   end

   always_comb begin
      wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
      rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
      case ({push, pop})
         2'b10:   count_d = count_q + FCNT_W'(1);
         2'b01:   count_d = count_q - FCNT_W'(1);
         default: count_d = count_q;
      endcase
      ready_d = (count_d != FIFO_FULL);
      busy_d  = (state_d != S_IDLE) || (count_d != '0);
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q   <= S_IDLE;
         baud_q    <= '0;
         bit_idx_q <= 3'd0;
         txd_q     <= 1'b1;
         ready_q   <= 1'b1;
         busy_q    <= 1'b0;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
      end else begin
         state_q   <= state_d;
         baud_q    <= baud_d;
         bit_idx_q <= bit_idx_d;
         txd_q     <= txd_d;
         ready_q   <= ready_d;
         busy_q    <= busy_d;
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         count_q   <= count_d;
      end
   end

   // Payload storage carries no reset; it is only read after being written.
   always_ff @(posedge i_clk) begin
      if (push) begin
         mem_q[wr_ptr_q] <= i_data;
      end
      shift_q <= shift_d;
`ifdef UART_TX_PARITY_EN
      parity_q <= parity_d;
`endif
   end

   assign o_txd   = txd_q;
   assign o_ready = ready_q;
   assign o_busy  = busy_q;

endmodule

// File: tb/tb_uart_tx.sv
// Scoreboard bench for uart_tx: a line monitor decodes every frame clock by
// clock and compares it against bytes queued when they were pushed.
module tb_uart_tx;

   localparam int C  = 4;
   localparam int D  = 4;
   localparam int S  = 1;
`ifdef UART_TX_PARITY_EN
   localparam int P  = 1;
`else
   localparam int P  = 0;
`endif
   localparam int NB    = 10 + S - 1 + P;
   localparam int FRAME = NB * C;
   localparam int C2    = 5;
   localparam int S2    = 2;
   localparam int NB2   = 10 + S2 - 1 + P;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] i_data = 8'h00;
   logic       i_valid = 1'b0;
   logic       o_ready, o_txd, o_busy;
   logic [7:0] i_data2 = 8'h00;
   logic       i_valid2 = 1'b0;
   logic       o_ready2, o_txd2, o_busy2;

   uart_tx #(.CLKS_PER_BIT(C), .FIFO_DEPTH(D), .STOP_BITS(S)) u_dut (
      .i_clk(clk), .i_rst(rst), .i_data(i_data), .i_data_valid(i_valid),
      .o_ready(o_ready), .o_txd(o_txd), .o_busy(o_busy));

   uart_tx #(.CLKS_PER_BIT(C2), .FIFO_DEPTH(D), .STOP_BITS(S2)) u_dut2 (
      .i_clk(clk), .i_rst(rst), .i_data(i_data2), .i_data_valid(i_valid2),
      .o_ready(o_ready2), .o_txd(o_txd2), .o_busy(o_busy2));

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int         n_chk = 0;
   int         n_err = 0;
   logic [7:0] sb_q[$];
   int         start_q[$];
   logic       mon_busy = 1'b0;
   int         rx_count = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   task automatic rx_frame();
      logic [7:0]    eb;
      logic [7:0]    got;
      logic [NB-1:0] ebit;
      logic          obs;
      bit            abort;
      abort = 1'b0;
      got   = 8'h00;
      if (sb_q.size() == 0) begin
         chk("frame_expected", sb_q.size(), 1);
         eb = 8'h00;
      end else begin
         eb = sb_q.pop_front();
      end
      start_q.push_back(cyc);
      ebit    = '1;
      ebit[0] = 1'b0;
      for (int i = 0; i < 8; i++) ebit[i+1] = eb[i];
      if (P == 1) ebit[9] = ^eb;
      for (int b = 0; b < NB; b++) begin
         obs = ebit[b];
         for (int c = 0; c < C; c++) begin
            if (b != 0 || c != 0) @(negedge clk);
            if (rst) begin
               abort = 1'b1;
               break;
            end
            if (o_txd !== ebit[b]) obs = o_txd;
         end
         if (abort) break;
         if (b >= 1 && b <= 8) got[b-1] = obs;
         chk($sformatf("txd_bit%0d_byte%02h", b, eb), obs, ebit[b]);
      end
      if (!abort) begin
         chk("rx_byte", got, eb);
         rx_count++;
      end
   endtask

   initial begin
      forever begin
         @(negedge clk);
         if (!rst && o_txd === 1'b0) begin
            mon_busy = 1'b1;
            rx_frame();
            mon_busy = 1'b0;
         end
      end
   end

   task automatic send(input logic [7:0] b, output int pc);
      @(negedge clk);
      chk($sformatf("ready_before_%02h", b), o_ready, 1);
      i_data  = b;
      i_valid = 1'b1;
      sb_q.push_back(b);
      @(posedge clk);
      #1;
      pc      = cyc;
      i_valid = 1'b0;
      i_data  = 8'($urandom);
   endtask

   task automatic wait_done(input int lim);
      int t;
      t = 0;
      do begin
         @(negedge clk);
         t++;
      end while ((o_busy || mon_busy || sb_q.size() != 0) && t < lim);
      if (o_busy || mon_busy || sb_q.size() != 0)
         chk("wait_done_pending", sb_q.size() + int'(o_busy) + int'(mon_busy), 0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete, errors so far %0d", n_err);
      $fatal(1, "watchdog expired");
   end

   initial begin
      int pc, p1, p2, ns, lows, first, done;

      repeat (3) @(posedge clk);
      #1;
      chk("rst_txd",   o_txd,   1);
      chk("rst_ready", o_ready, 1);
      chk("rst_busy",  o_busy,  0);
      chk("rst_txd2",  o_txd2,  1);
      @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      // Single byte: latency, bit pattern and busy fall after the stop bit.
      ns = start_q.size();
      send(8'h55, pc);
      for (int n = 0; n <= FRAME + 1; n++) begin
         @(negedge clk);
         if (n == 0)         chk("busy_after_push", o_busy, 1);
         if (n == FRAME)     chk("busy_in_stop",    o_busy, 1);
         if (n == FRAME + 1) chk("busy_fall",       o_busy, 0);
      end
      if (start_q.size() > ns) chk("latency", start_q[ns] - pc, 1);
      else                     chk("frame_started", start_q.size(), ns + 1);
      wait_done(200);

      // Back-to-back frames with no idle gap.
      ns = start_q.size();
      send(8'hA3, p1);
      send(8'h0F, p2);
      wait_done(4 * FRAME);
      if (start_q.size() >= ns + 2) chk("b2b_gap", start_q[ns+1] - start_q[ns], FRAME);
      else                          chk("b2b_frames", start_q.size(), ns + 2);

      // Parity-sensitive bytes.
      send(8'h07, pc);
      wait_done(2 * FRAME);
      send(8'h03, pc);
      wait_done(2 * FRAME);

      // FIFO full: sixth write must be dropped.
      ns = rx_count;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         chk($sformatf("full_ready%0d", i), o_ready, (i < 5) ? 1 : 0);
         i_data  = 8'(i + 1);
         i_valid = 1'b1;
         if (i < 5) sb_q.push_back(8'(i + 1));
      end
      @(negedge clk);
      i_valid = 1'b0;
      chk("ready_after_full", o_ready, 0);
      wait_done(6 * FRAME + 100);
      chk("full_rx_count", rx_count - ns, 5);

      // Two stop bits, five clocks per bit, 0xFF.
      @(negedge clk);
      chk("d2_ready", o_ready2, 1);
      i_data2  = 8'hFF;
      i_valid2 = 1'b1;
      @(posedge clk);
      #1;
      i_valid2 = 1'b0;
      lows  = 0;
      first = -1;
      done  = -1;
      for (int t = 0; t < 200; t++) begin
         @(negedge clk);
         if (o_txd2 === 1'b0) lows++;
         if (first < 0 && o_txd2 === 1'b0) first = t;
         if (first >= 0 && done < 0 && o_busy2 === 1'b0) done = t;
      end
      chk("d2_first_low", first, 1);
      chk("d2_low_clocks", lows, (P == 1) ? 10 : 5);
      chk("d2_frame_len", done - first, NB2 * C2);

      // Asynchronous reset in the middle of a 0x00 frame.
      send(8'h00, pc);
      repeat (12) @(negedge clk);
      #2;
      rst = 1'b1;
      #1;
      chk("arst_txd",   o_txd,   1);
      chk("arst_busy",  o_busy,  0);
      chk("arst_ready", o_ready, 1);
      repeat (3) @(negedge clk);
      rst  = 1'b0;
      lows = 0;
      repeat (60) begin
         @(negedge clk);
         if (o_txd !== 1'b1) lows++;
      end
      chk("post_rst_low_clocks", lows, 0);
      chk("post_rst_busy", o_busy, 0);
      chk("post_rst_sb_left", sb_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- UART transmitter; the transmit-side counterpart of the team's uart_rx on the same serial link.
- Accepts bytes from on-chip logic through a valid/ready handshake and buffers them in a small FIFO.
- Serialises each byte as an 8N1 frame (start, 8 data LSB-first, STOP_BITS stop) on o_txd.
- Idle line high. Default bit timing matches uart_rx: 2 x 211 clocks per bit.

Parameters:
- CLKS_PER_BIT, 422: clocks per serial bit; legal range 2 and up.
- FIFO_DEPTH, 4: input FIFO entries; power of two, legal range 2 and up.
- STOP_BITS, 1: number of stop bits, 1 or 2.

Ports:
- i_clk  input  1  system clock.
- i_rst  input  1  reset, asynchronous, active-high.
- i_data  input  8  byte to send.
- i_data_valid  input  1  i_data is valid this cycle.
- o_ready  output  1  FIFO can accept a byte; registered.
- o_txd  output  1  serial output; registered, idle high.
- o_busy  output  1  frame in progress or FIFO non-empty.

Behaviour:
- Reset (async, i_rst=1): o_txd=1, o_ready=1, o_busy=0, FIFO empty, FSM=IDLE, bit counter=0, all cleared immediately. Reset mid-frame aborts the frame; the line returns high at once and no partial frame resumes.
- Clocking: single clock domain, all state on posedge i_clk.
- Push: a byte is accepted on an edge where i_data_valid && o_ready. Writes with o_ready=0 are dropped silently.
- o_ready: registered, equals (count != FIFO_DEPTH) for the next cycle. A pop on the same edge does not re-enable a push that edge.
- Simultaneous push and pop: count unchanged; data order preserved, FIFO is strictly in order.
- Baud counter: 0..CLKS_PER_BIT-1, width $clog2(CLKS_PER_BIT). Resets to 0 at every bit boundary. Each bit is held for exactly CLKS_PER_BIT clocks.
- FSM states: IDLE, START, DATA, [PARITY], STOP.
- IDLE: o_txd=1. If the FIFO is non-empty, pop the head into the shift register, drive o_txd=0 and go to START.
- Latency: a byte pushed into an empty FIFO at edge k gives o_txd=0 from edge k+1.
- START: held for one bit period, then go to DATA with o_txd=bit0.
- DATA: 8 bits, LSB first; a 3-bit index counts 0..7. After bit 7, go to PARITY if enabled, else STOP.
- STOP: o_txd=1 for STOP_BITS x CLKS_PER_BIT clocks.
- End of STOP: if the FIFO is non-empty, pop and go directly to START, so the next start bit follows with zero idle gap. Otherwise go to IDLE.
- o_busy: registered, high when FSM != IDLE or the FIFO is non-empty.
- Frame length: (10 + STOP_BITS - 1) x CLKS_PER_BIT clocks without parity; one more bit period with parity.
- i_data is ignored when not accepted. The shift register and FIFO contents are don't-care when unused.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined: insert a PARITY state after DATA, one bit period, o_txd = ^data (even parity: total ones across data+parity is even). Frame becomes 8E1 / 8E2.
- Undefined: no PARITY state, no parity logic; DATA goes straight to STOP.

Test Plan (CLKS_PER_BIT=4, FIFO_DEPTH=4, STOP_BITS=1 unless noted):
- Reset: assert i_rst asynchronously mid-frame while sending 0x00 -> o_txd=1, o_busy=0, o_ready=1 immediately. No further low bits after release.
- Single byte 0x55 pushed at edge k -> o_txd from edge k+1 is 0,1,0,1,0,1,0,1,0,1, each held 4 clocks (40 clocks total). o_busy falls after the stop bit.
- Back-to-back 0xA3 then 0x0F -> second start bit begins on the clock right after the first stop bit ends. Bits LSB-first: 1,1,0,0,0,1,0,1 then 1,1,1,1,0,0,0,0.
- FIFO full: assert i_data_valid for 6 consecutive cycles with 0x01..0x06 -> 0x01..0x05 accepted, o_ready=0 after the 5th, 0x06 dropped. Line emits 0x01..0x05 in order.
- STOP_BITS=2, CLKS_PER_BIT=5, byte 0xFF -> low for 5 clocks, then high for 50 clocks; frame length 55 clocks.
- UART_TX_PARITY_EN defined: 0x07 -> parity bit 1; 0x03 -> parity bit 0. Frame 11 bits x 4 = 44 clocks.
